// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage sequencer. Owns the PC, issues one instruction-memory
// request at a time, and loads the IF/ID slot (pc, pc+4, instr, valid).
// Applies hazard stalls and EX redirects, and drops responses made stale by a redirect.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   stall_i              IF/ID must hold its contents this cycle
//   redirect_i/_pc_i     taken branch/jump from EX and its target (bits[1:0] ignored)
//   imem_req_o/addr_o    fetch request and address (address is the PC register)
//   imem_gnt_i           memory accepted the request this cycle
//   imem_rvalid_i/rdata  read response
//   pc_o, pc_plus_4_o, instr_o, instr_valid_o   IF/ID slot contents
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus_4_o,
  output logic [31:0] instr_o,
  output logic        instr_valid_o
);

  localparam int unsigned XLEN    = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] outreq_pc_q, outreq_pc_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] slot_pc_q, slot_pc_d;
  logic [XLEN-1:0] slot_pc4_q, slot_pc4_d;
  logic [XLEN-1:0] slot_instr_q, slot_instr_d;
  logic            slot_valid_q, slot_valid_d;

  logic            fetch_req;
  logic            fetch_acc;
  logic            slot_load;
  logic [XLEN-1:0] load_pc;
  logic [XLEN-1:0] load_instr;

  // A request is withheld only while a live instruction is being held by a stall.
  assign fetch_req = (state_q == ST_REQ) && !(slot_valid_q && stall_i);
  assign fetch_acc = fetch_req && imem_gnt_i;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      outreq_pc_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      slot_pc_q    <= '0;
      slot_pc4_q   <= '0;
      slot_instr_q <= NOP_INSTR;
      slot_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      outreq_pc_q  <= outreq_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      slot_pc_q    <= slot_pc_d;
      slot_pc4_q   <= slot_pc4_d;
      slot_instr_q <= slot_instr_d;
      slot_valid_q <= slot_valid_d;
    end
  end

  // Next-state, PC, skid and slot update; redirect overrides everything last.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    outreq_pc_d  = outreq_pc_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    slot_pc_d    = slot_pc_q;
    slot_pc4_d   = slot_pc4_q;
    slot_instr_d = slot_instr_q;
    slot_valid_d = slot_valid_q;
    slot_load    = 1'b0;
    load_pc      = outreq_pc_q;
    load_instr   = imem_rdata_i;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (fetch_acc) begin
          outreq_pc_d = pc_q;
          pc_d        = pc_q + PC_STEP;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          if (!slot_valid_q || !stall_i) begin
            slot_load = 1'b1;
          end else begin
            skid_valid_d = 1'b1;
            skid_pc_d    = outreq_pc_q;
            skid_instr_d = imem_rdata_i;
            state_d      = ST_HOLD;
          end
          if (!slot_valid_q || !stall_i) begin
            state_d = ST_REQ;
          end
        end
      end
      ST_HOLD: begin
        if (!stall_i) begin
          slot_load    = skid_valid_q;
          load_pc      = skid_pc_q;
          load_instr   = skid_instr_q;
          skid_valid_d = 1'b0;
          state_d      = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (imem_rvalid_i) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase

    // Load wins over consume; a consumed slot keeps its last pc/instr values.
    if (slot_load) begin
      slot_pc_d    = load_pc;
      slot_pc4_d   = load_pc + PC_STEP;
      slot_instr_d = load_instr;
      slot_valid_d = 1'b1;
    end else if (slot_valid_q && !stall_i) begin
      slot_valid_d = 1'b0;
    end

    if (redirect_i) begin
      pc_d         = {redirect_pc_i[XLEN-1:2], 2'b00};
      slot_valid_d = 1'b0;
      slot_instr_d = NOP_INSTR;
      skid_valid_d = 1'b0;
      skid_pc_d    = '0;
      skid_instr_d = '0;
      // Go to DRAIN only when a response is still owed by memory.
      case (state_q)
        ST_REQ:   state_d = fetch_acc ? ST_DRAIN : ST_REQ;
        ST_WAIT:  state_d = imem_rvalid_i ? ST_REQ : ST_DRAIN;
        // A response arriving in the same cycle still ends the drain.
        ST_DRAIN: state_d = imem_rvalid_i ? ST_REQ : ST_DRAIN;
        default:  state_d = ST_REQ;
      endcase
    end
  end

  assign imem_req_o    = fetch_req;
  assign imem_addr_o   = pc_q;
  assign pc_o          = slot_pc_q;
  assign pc_plus_4_o   = slot_pc4_q;
  assign instr_o       = slot_instr_q;
  assign instr_valid_o = slot_valid_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed scenarios plus a randomized run checked against a
// program-order fetch/delivery model and a single-outstanding memory model.
module tb_if_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] pc_o, pc_plus_4_o, instr_o;
  logic        instr_valid_o;

  int n_cmp = 0;
  int n_fail = 0;

  // memory model controls / state
  bit          gnt_always = 1'b1;
  int          dly_min = 0;
  int          dly_max = 0;
  bit          mem_busy = 1'b0;
  bit          busy_start = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  if_fetch_ctrl #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .pc_o(pc_o), .pc_plus_4_o(pc_plus_4_o), .instr_o(instr_o), .instr_valid_o(instr_valid_o)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
  endfunction

  // Instruction memory: one outstanding request, response after a configurable delay.
  always begin
    @(negedge clk);
    busy_start = mem_busy;
    if (mem_busy && mem_cnt == 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(mem_addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    imem_gnt_i = gnt_always ? 1'b1 : ($urandom_range(0, 2) != 0);
    #1;
    if (imem_rvalid_i) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (imem_req_o && imem_gnt_i && !rst && !busy_start) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr_o;
      mem_cnt  = $urandom_range(dly_min, dly_max);
    end
  end

  // Returns at the negedge where rst is released; DUT is in its boot cycle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10 && mem_busy; i++) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    gnt_always = 1'b1; dly_min = 0; dly_max = 0;
    do_reset();
    #2;
    n_cmp++;
    if ({instr_valid_o, pc_o, pc_plus_4_o, instr_o, imem_req_o} !== {1'b0, 32'h0, 32'h0, NOP, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b pc=%h pc4=%h instr=%h req=%b, want 0/0/0/%h/0",
               instr_valid_o, pc_o, pc_plus_4_o, instr_o, imem_req_o, NOP);
    end
    @(negedge clk); #2;
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_first_req: got req=%b addr=%h, want 1/%h", imem_req_o, imem_addr_o, RST_PC);
    end
  endtask

  task automatic test_zero_wait();
    int g_cyc[$]; logic [31:0] g_adr[$];
    int v_cyc[$]; logic [31:0] v_pc[$]; logic [31:0] v_pc4[$]; logic [31:0] v_ins[$];
    gnt_always = 1'b1; dly_min = 0; dly_max = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #2;
      if (imem_req_o && imem_gnt_i) begin g_cyc.push_back(i); g_adr.push_back(imem_addr_o); end
      if (instr_valid_o) begin
        v_cyc.push_back(i); v_pc.push_back(pc_o); v_pc4.push_back(pc_plus_4_o); v_ins.push_back(instr_o);
      end
    end
    n_cmp++;
    if (g_adr.size() < 3 || v_pc.size() < 3) begin
      n_fail++;
      $display("FAIL zw_counts: got grants=%0d slots=%0d, want >=3 each", g_adr.size(), v_pc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (g_adr[k] !== 32'(4 * k)) begin
          n_fail++; $display("FAIL zw_addr%0d: got %h want %h", k, g_adr[k], 32'(4 * k));
        end
        n_cmp++;
        if (v_pc[k] !== 32'(4 * k) || v_pc4[k] !== 32'(4 * k + 4) || v_ins[k] !== mem_word(32'(4 * k))) begin
          n_fail++;
          $display("FAIL zw_slot%0d: got pc=%h pc4=%h instr=%h want %h/%h/%h", k, v_pc[k], v_pc4[k],
                   v_ins[k], 32'(4 * k), 32'(4 * k + 4), mem_word(32'(4 * k)));
        end
      end
      n_cmp++;
      if (v_cyc[0] !== g_cyc[0] + 2) begin
        n_fail++; $display("FAIL zw_latency: slot at cycle %0d want %0d", v_cyc[0], g_cyc[0] + 2);
      end
      n_cmp++;
      if (v_cyc[1] - v_cyc[0] !== 2 || v_cyc[2] - v_cyc[1] !== 2) begin
        n_fail++; $display("FAIL zw_throughput: slot cycles %0d,%0d,%0d want spacing 2", v_cyc[0], v_cyc[1], v_cyc[2]);
      end
    end
  endtask

  task automatic test_stall();
    bit found = 1'b0; bit got = 1'b0;
    gnt_always = 1'b1; dly_min = 0; dly_max = 0;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #2;
      if (imem_req_o && imem_gnt_i && imem_addr_o == 32'h4) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++; $display("FAIL stall_setup: got no grant of 0x4, want one within 20 cycles");
    end
    @(negedge clk);
    @(negedge clk);
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #2;
      n_cmp++;
      if (instr_valid_o !== 1'b1 || pc_o !== 32'h4 || pc_plus_4_o !== 32'h8 ||
          instr_o !== mem_word(32'h4) || imem_req_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got valid=%b pc=%h pc4=%h instr=%h req=%b want 1/4/8/%h/0",
                 i, instr_valid_o, pc_o, pc_plus_4_o, instr_o, imem_req_o, mem_word(32'h4));
      end
    end
    @(negedge clk);
    stall_i = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      #2;
      if (instr_valid_o && pc_o !== 32'h4) got = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!got || pc_o !== 32'h8 || instr_o !== mem_word(32'h8)) begin
      n_fail++;
      $display("FAIL stall_release: got seen=%b pc=%h instr=%h want 1/00000008/%h", got, pc_o, instr_o, mem_word(32'h8));
    end
  endtask

  // Runs n cycles and reports the first grant address and first slot pc/instr seen.
  task automatic observe(input int n, output bit g_seen, output logic [31:0] g_first,
                         output bit v_seen, output logic [31:0] v_pc, output logic [31:0] v_ins);
    g_seen = 1'b0; v_seen = 1'b0; g_first = '0; v_pc = '0; v_ins = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #2;
      if (!g_seen && imem_req_o && imem_gnt_i) begin g_seen = 1'b1; g_first = imem_addr_o; end
      if (!v_seen && instr_valid_o) begin v_seen = 1'b1; v_pc = pc_o; v_ins = instr_o; end
    end
  endtask

  task automatic test_redirect_wait();
    bit found = 1'b0; bit gs, vs; logic [31:0] ga, vp, vi;
    gnt_always = 1'b1; dly_min = 2; dly_max = 2;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #2;
      if (imem_req_o && imem_gnt_i && imem_addr_o == 32'h4) found = 1'b1;
    end
    @(negedge clk);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    @(negedge clk);
    redirect_i = 1'b0;
    #2;
    n_cmp++;
    if (!found || instr_valid_o !== 1'b0 || instr_o !== NOP) begin
      n_fail++;
      $display("FAIL rw_flush: got setup=%b valid=%b instr=%h want 1/0/%h", found, instr_valid_o, instr_o, NOP);
    end
    observe(12, gs, ga, vs, vp, vi);
    n_cmp++;
    if (!gs || ga !== 32'h100) begin
      n_fail++; $display("FAIL rw_next_addr: got seen=%b addr=%h want 1/00000100", gs, ga);
    end
    n_cmp++;
    if (!vs || vp !== 32'h100 || vi !== mem_word(32'h100)) begin
      n_fail++; $display("FAIL rw_first_slot: got seen=%b pc=%h instr=%h want 1/00000100/%h", vs, vp, vi, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_gnt();
    bit gs, vs; logic [31:0] ga, vp, vi;
    gnt_always = 1'b1; dly_min = 0; dly_max = 0;
    do_reset();
    @(negedge clk);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    #2;
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RST_PC) begin
      n_fail++; $display("FAIL rg_setup: got req=%b addr=%h want 1/%h", imem_req_o, imem_addr_o, RST_PC);
    end
    @(negedge clk);
    redirect_i = 1'b0;
    #2;
    n_cmp++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL rg_drain: got valid=%b req=%b want 0/0", instr_valid_o, imem_req_o);
    end
    observe(12, gs, ga, vs, vp, vi);
    n_cmp++;
    if (!gs || ga !== 32'h200) begin
      n_fail++; $display("FAIL rg_next_addr: got seen=%b addr=%h want 1/00000200", gs, ga);
    end
    n_cmp++;
    if (!vs || vp !== 32'h200 || vi !== mem_word(32'h200)) begin
      n_fail++; $display("FAIL rg_first_slot: got seen=%b pc=%h instr=%h want 1/00000200/%h", vs, vp, vi, mem_word(32'h200));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] g_adr[$]; logic [31:0] v_pc[$]; logic [31:0] v_pc4[$];
    gnt_always = 1'b1; dly_min = 0; dly_max = 0;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (imem_req_o && imem_gnt_i) g_adr.push_back(imem_addr_o);
      if (instr_valid_o) begin v_pc.push_back(pc_o); v_pc4.push_back(pc_plus_4_o); end
      @(negedge clk);
    end
    n_cmp++;
    if (g_adr.size() < 2 || g_adr[0] !== 32'hFFFF_FFFC || g_adr[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_addrs: got n=%0d first=%h second=%h want FFFFFFFC/00000000", g_adr.size(),
               g_adr.size() > 0 ? g_adr[0] : 32'hX, g_adr.size() > 1 ? g_adr[1] : 32'hX);
    end
    n_cmp++;
    if (v_pc.size() < 2 || v_pc[0] !== 32'hFFFF_FFFC || v_pc4[0] !== 32'h0 || v_pc[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_slots: got n=%0d pc0=%h pc4_0=%h pc1=%h want FFFFFFFC/00000000/00000000", v_pc.size(),
               v_pc.size() > 0 ? v_pc[0] : 32'hX, v_pc4.size() > 0 ? v_pc4[0] : 32'hX, v_pc.size() > 1 ? v_pc[1] : 32'hX);
    end
  endtask

  task automatic test_reset_in_wait();
    bit found = 1'b0; bit gs, vs; logic [31:0] ga, vp, vi;
    gnt_always = 1'b1; dly_min = 1; dly_max = 1;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #2;
      if (imem_req_o && imem_gnt_i && imem_addr_o == 32'h8) found = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    n_cmp++;
    if (!found || imem_rvalid_i !== 1'b1 || instr_valid_o !== 1'b0 || pc_o !== 32'h0 ||
        pc_plus_4_o !== 32'h0 || instr_o !== NOP || imem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait_outputs: got setup=%b rvalid=%b valid=%b pc=%h pc4=%h instr=%h req=%b want 1/1/0/0/0/%h/0",
               found, imem_rvalid_i, instr_valid_o, pc_o, pc_plus_4_o, instr_o, imem_req_o, NOP);
    end
    dly_min = 0; dly_max = 0;
    observe(8, gs, ga, vs, vp, vi);
    n_cmp++;
    if (!gs || ga !== RST_PC || !vs || vp !== RST_PC || vi !== mem_word(RST_PC)) begin
      n_fail++;
      $display("FAIL rst_wait_refetch: got g=%b addr=%h v=%b pc=%h instr=%h want 1/%h/1/%h/%h",
               gs, ga, vs, vp, vi, RST_PC, RST_PC, mem_word(RST_PC));
    end
  endtask

  // Random stall/redirect/grant/latency against a program-order model.
  task automatic test_random();
    logic [31:0] exp_fetch, exp_deliver;
    logic [31:0] sv_pc, sv_pc4, sv_ins, prev_addr;
    bit frz_prev, redir_prev, req_prev, gnt_prev;
    int delivered;
    gnt_always = 1'b0; dly_min = 0; dly_max = 3;
    do_reset();
    exp_fetch = RST_PC; exp_deliver = RST_PC; delivered = 0;
    frz_prev = 1'b0; redir_prev = 1'b0; req_prev = 1'b0; gnt_prev = 1'b0;
    sv_pc = '0; sv_pc4 = '0; sv_ins = '0; prev_addr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      stall_i       = ($urandom_range(0, 3) == 0);
      redirect_i    = ($urandom_range(0, 24) == 0);
      redirect_pc_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
      #2;
      if (redir_prev) begin
        n_cmp++;
        if (instr_valid_o !== 1'b0 || instr_o !== NOP) begin
          n_fail++; $display("FAIL rnd_flush@%0d: got valid=%b instr=%h want 0/%h", cyc, instr_valid_o, instr_o, NOP);
        end
      end
      if (frz_prev) begin
        n_cmp++;
        if (instr_valid_o !== 1'b1 || pc_o !== sv_pc || pc_plus_4_o !== sv_pc4 || instr_o !== sv_ins) begin
          n_fail++; $display("FAIL rnd_freeze@%0d: got valid=%b pc=%h instr=%h want 1/%h/%h", cyc, instr_valid_o, pc_o, instr_o, sv_pc, sv_ins);
        end
      end
      if (busy_start) begin
        n_cmp++;
        if (imem_req_o !== 1'b0) begin
          n_fail++; $display("FAIL rnd_outstanding@%0d: got req=%b want 0", cyc, imem_req_o);
        end
      end
      if (req_prev && !gnt_prev && !redir_prev) begin
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== prev_addr) begin
          n_fail++; $display("FAIL rnd_req_stable@%0d: got req=%b addr=%h want 1/%h", cyc, imem_req_o, imem_addr_o, prev_addr);
        end
      end
      if (imem_req_o) begin
        n_cmp++;
        if (imem_addr_o !== exp_fetch) begin
          n_fail++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, imem_addr_o, exp_fetch);
        end
      end
      if (instr_valid_o) begin
        n_cmp++;
        if (pc_plus_4_o !== pc_o + 32'd4 || instr_o !== mem_word(pc_o)) begin
          n_fail++; $display("FAIL rnd_slot@%0d: got pc=%h pc4=%h instr=%h want pc4=%h instr=%h",
                             cyc, pc_o, pc_plus_4_o, instr_o, pc_o + 32'd4, mem_word(pc_o));
        end
      end
      if (instr_valid_o && !stall_i && !redirect_i) begin
        n_cmp++;
        if (pc_o !== exp_deliver) begin
          n_fail++; $display("FAIL rnd_order@%0d: got pc=%h want %h", cyc, pc_o, exp_deliver);
        end
        exp_deliver = exp_deliver + 32'd4;
        delivered++;
      end
      if (redirect_i) begin
        exp_fetch   = {redirect_pc_i[31:2], 2'b00};
        exp_deliver = {redirect_pc_i[31:2], 2'b00};
      end else if (imem_req_o && imem_gnt_i) begin
        exp_fetch = exp_fetch + 32'd4;
      end
      frz_prev   = instr_valid_o && stall_i && !redirect_i;
      sv_pc = pc_o; sv_pc4 = pc_plus_4_o; sv_ins = instr_o;
      redir_prev = redirect_i;
      req_prev   = imem_req_o;
      gnt_prev   = imem_gnt_i;
      prev_addr  = imem_addr_o;
    end
    @(negedge clk);
    stall_i = 1'b0; redirect_i = 1'b0;
    n_cmp++;
    if (delivered < 100) begin
      n_fail++; $display("FAIL rnd_progress: got %0d delivered want >=100", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_wait();
    test_redirect_gnt();
    test_wrap();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
